// File: rtl/key_debounce_pkg.sv
// ============================================================================
// Module   : key_debounce_pkg
// Brief    : Shared state encoding and counter widths for the key debouncer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  localparam int CNT_W  = 16;
  localparam int HOLD_W = 24;

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// ============================================================================
// Module   : key_debounce_ch
// Brief    : One debounced key channel: 2-flop synchronizer, 4-state FSM,
//            press/release pulses; long-press pulse with KEY_DEBOUNCE_LONG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LONG_CYCLES     = 16777216
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
`ifdef KEY_DEBOUNCE_LONG_EN
  ,
  output logic key_long
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_s;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             r_press;
  logic             r_release;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = '0;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      STABLE_LO: if (r_s) w_state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (!r_s) begin
          w_state_nxt = STABLE_LO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STABLE_HI: if (!r_s) w_state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (r_s) begin
          w_state_nxt = STABLE_HI;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = STABLE_LO;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = STABLE_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_s       <= 1'b0;
      r_state   <= STABLE_LO;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= key_in;
      r_s       <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // The upper state bit is exactly the debounced level under this encoding.
  assign key_level   = r_state[1];
  assign key_press   = r_press;
  assign key_release = r_release;

`ifdef KEY_DEBOUNCE_LONG_EN
  localparam int HOLD_CAP_I = (LONG_CYCLES > (2 ** HOLD_W) - 1) ? (2 ** HOLD_W) - 1 : LONG_CYCLES;
  localparam logic [HOLD_W-1:0] HOLD_CAP  = HOLD_W'(HOLD_CAP_I);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 2);

  logic [HOLD_W-1:0] r_hold;
  logic              r_long;

  // Cleared only on a real press, so a release bounce cannot re-arm the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_press_nxt) begin
        r_hold <= '0;
      end else if (r_state[1]) begin
        if (r_hold != HOLD_CAP) r_hold <= r_hold + 1'b1;
        if (r_hold == HOLD_FIRE) r_long <= 1'b1;
      end
    end
  end

  assign key_long = r_long;
`endif

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module   : key_debounce
// Brief    : NKEY independent debounced key channels. Optional long-press
//            output enabled by defining KEY_DEBOUNCE_LONG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NKEY            = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LONG_CYCLES     = 16777216
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NKEY-1:0] key_in,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release
`ifdef KEY_DEBOUNCE_LONG_EN
  ,
  output logic [NKEY-1:0] key_long
`endif
);

  for (genvar i = 0; i < NKEY; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
`ifdef KEY_DEBOUNCE_LONG_EN
      ,
      .key_long   (key_long[i])
`endif
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ============================================================================
// Module   : tb_key_debounce
// Brief    : Randomized and directed bench for key_debounce against a
//            run-length reference model (KEY_DEBOUNCE_LONG_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debounce;

  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_in = '0;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
`ifdef KEY_DEBOUNCE_LONG_EN
  logic [N-1:0] key_long;
`endif

  key_debounce #(
    .NKEY           (N),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
`ifdef KEY_DEBOUNCE_LONG_EN
    ,
    .key_long   (key_long)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: a change is accepted once the synchronized input has differed
  // from the accepted level on D+1 consecutive edges.
  logic [N-1:0] m_sync1, m_s, m_level, m_press, m_rel, m_long;
  int           m_run  [N];
  int           m_hold [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_sync1[i] = 1'b0; m_s[i] = 1'b0; m_level[i] = 1'b0;
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_long[i] = 1'b0;
        m_run[i] = 0; m_hold[i] = 0;
      end else begin
        logic old_level;
        old_level  = m_level[i];
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_long[i] = 1'b0;
        m_run[i]   = (m_s[i] != old_level) ? m_run[i] + 1 : 0;
        if (m_run[i] == D + 1) begin
          m_level[i] = m_s[i];
          m_run[i]   = 0;
          if (m_s[i]) m_press[i] = 1'b1;
          else        m_rel[i]   = 1'b1;
        end
        if (m_press[i]) begin
          m_hold[i] = 0;
        end else if (old_level) begin
          if (m_hold[i] < L) m_hold[i]++;
          if (m_hold[i] == L - 1 && m_hold[i] != L) m_long[i] = (m_hold[i] == L - 1);
        end
        m_s[i]     = m_sync1[i];
        m_sync1[i] = key_in[i];
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] k);
    @(negedge clk);
    rst    = r;
    key_in = k;
    @(posedge clk);
    model_edge();
    #1;
    chk("level",   32'(key_level),   32'(m_level));
    chk("press",   32'(key_press),   32'(m_press));
    chk("release", 32'(key_release), 32'(m_rel));
`ifdef KEY_DEBOUNCE_LONG_EN
    chk("long",    32'(key_long),    32'(m_long));
`endif
  endtask

  // Applies k for 12 edges; edge 0 is the first edge sampling k.
  task automatic run_lat(input logic [N-1:0] k, input int ch, input bit want_press, input string tag);
    int first = -1;
    for (int e = 0; e < 12; e++) begin
      step(1'b0, k);
      if (first < 0 && (want_press ? key_press[ch] : key_release[ch])) first = e;
    end
    chk(tag, 32'(first), 32'(D + 2));
  endtask

  initial begin
    int hold_left [N];
    logic [N-1:0] k;
    k = '0;
    for (int c = 0; c < 3; c++) step(1'b1, 2'b00);

    // Clean press and release on channel 0.
    run_lat(2'b01, 0, 1'b1, "press_lat");
    run_lat(2'b00, 0, 1'b0, "release_lat");

    // Bounce: 1,1,0,0 then hold 1.
    step(1'b0, 2'b01); step(1'b0, 2'b01);
    step(1'b0, 2'b00); step(1'b0, 2'b00);
    run_lat(2'b01, 0, 1'b1, "bounce_lat");
    run_lat(2'b00, 0, 1'b0, "bounce_rel_lat");

    // Simultaneous channels.
    run_lat(2'b11, 1, 1'b1, "sim_press_lat");
    run_lat(2'b00, 1, 1'b0, "sim_release_lat");

    // Reset mid-wait with the key still held.
    for (int c = 0; c < 3; c++) step(1'b0, 2'b01);
    for (int c = 0; c < 2; c++) step(1'b1, 2'b01);
    run_lat(2'b01, 0, 1'b1, "rst_press_lat");
    run_lat(2'b00, 0, 1'b0, "rst_release_lat");

`ifdef KEY_DEBOUNCE_LONG_EN
    begin
      int long_edge = -1;
      int long_cnt  = 0;
      for (int e = 0; e < 32; e++) begin
        step(1'b0, 2'b10);
        if (key_long[1]) begin
          long_cnt++;
          if (long_edge < 0) long_edge = e;
        end
      end
      chk("long_edge", 32'(long_edge), 32'(D + 2 + L - 1));
      chk("long_once", 32'(long_cnt), 32'd1);
      for (int e = 0; e < 12; e++) begin
        step(1'b0, 2'b00);
        if (key_long[1]) long_cnt++;
      end
      chk("long_after_rel", 32'(long_cnt), 32'd1);
    end
`endif

    // Randomized holds of varying length, with occasional resets.
    for (int i = 0; i < N; i++) hold_left[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold_left[i] == 0) begin
          k[i]         = 1'($urandom_range(1, 0));
          hold_left[i] = (($urandom_range(7, 0) == 0) ? L + 4 : int'($urandom_range(D + 6, 1)));
        end
        hold_left[i]--;
      end
      step(($urandom_range(149, 0) == 0), k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter NKEY, default 2: number of independent key channels, range 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 65536: consecutive stable cycles needed to accept a level change, range 2..65536.
REQ-003 Parameter LONG_CYCLES, default 16777216: stable-high cycles before a long-press pulse, range 2..2^24; used only when KEY_DEBOUNCE_LONG_EN is defined.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 key_in  input  NKEY  raw asynchronous key or switch levels, 1 = pressed.
REQ-007 key_level  output  NKEY  debounced level per channel.
REQ-008 key_press  output  NKEY  one-cycle pulse on an accepted 0->1 change.
REQ-009 key_release  output  NKEY  one-cycle pulse on an accepted 1->0 change.
REQ-010 key_long  output  NKEY  one-cycle long-press pulse; present only with KEY_DEBOUNCE_LONG_EN.

Function
REQ-011 Each channel shall pass key_in[i] through a two-flop synchronizer; the second-flop output is s[i].
REQ-012 Each channel shall run a 4-state FSM:
- STABLE_LO: s=1 -> WAIT_HI, count cleared.
- WAIT_HI: s=0 -> STABLE_LO; count reaches DEBOUNCE_CYCLES-1 with s=1 -> STABLE_HI.
- STABLE_HI: s=0 -> WAIT_LO, count cleared.
- WAIT_LO: s=1 -> STABLE_HI; count reaches DEBOUNCE_CYCLES-1 with s=0 -> STABLE_LO.
REQ-013 The count shall be 16 bits wide; it increments once per cycle in a WAIT state while s differs from key_level, is cleared on every other transition, and shall never wrap.
REQ-014 key_level shall be 1 in STABLE_HI and WAIT_LO, 0 in STABLE_LO and WAIT_HI, and shall be registered.
REQ-015 key_press shall pulse on the same edge that enters STABLE_HI from WAIT_HI; key_release shall pulse on the same edge that enters STABLE_LO from WAIT_LO; each pulse lasts exactly one cycle.
REQ-016 Latency: a key_in step held steady shall change key_level DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-017 A bounce, meaning s returning to key_level at any cycle before acceptance, shall produce no pulse and no key_level change, and the following valid edge shall restart the count from 0.
REQ-018 Channels shall be fully independent; simultaneous accepted changes on several channels shall pulse in the same cycle.
REQ-019 key_press and key_release shall never both be high on one channel in the same cycle.

Reset
REQ-020 While rst=1 at a clock edge: synchronizer flops shall be 0, all FSMs shall be STABLE_LO, all counters 0, and key_level, key_press, key_release and key_long shall be all-zero.
REQ-021 Reset asserted mid-debounce shall abort the pending change without emitting a pulse.
REQ-022 A key already held high at reset release shall produce key_press after DEBOUNCE_CYCLES+2 cycles.

Configuration
REQ-023 When KEY_DEBOUNCE_LONG_EN is defined, each channel shall add a 24-bit hold counter:
- It clears on entry to STABLE_HI.
- It increments in STABLE_HI and WAIT_LO and saturates at LONG_CYCLES.
- key_long[i] pulses for one cycle on the edge the counter reaches LONG_CYCLES-1.
- There is at most one key_long pulse per press.
REQ-024 When KEY_DEBOUNCE_LONG_EN is not defined, the hold counter and the key_long port shall be absent and all other behaviour shall be unchanged.

Structure
REQ-025 A shared package key_debounce_pkg shall hold the FSM state encoding (2 bits: STABLE_LO=0, WAIT_HI=1, STABLE_HI=2, WAIT_LO=3) and the counter-width constants (16 and 24).
REQ-026 Each channel shall be one sub-module, key_debounce_ch, instantiated NKEY times by a generate loop; the top level shall contain no other logic.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, NKEY=2)
REQ-027 Clean press: key_in 00->01 at edge 0 -> key_level[0]=1 and key_press=01 (one cycle) at edge 6; key_release stays 00.
REQ-028 Bounce: key_in[0] toggles 1,0,1 every 2 cycles and then holds 1 -> no pulse during the toggling; a single key_press 6 edges after the final rise.
REQ-029 Simultaneous: key_in 00->11 -> key_press=11 in one cycle; then 11->00 -> key_release=11 six edges later.
REQ-030 Reset mid-wait: rst=1 three edges after a rise, with key_in still high -> outputs 0 during reset; key_press 6 edges after rst falls.
REQ-031 Long press (macro defined): hold key_in[1]=1 -> key_press[1] at edge 6 and key_long[1] at edge 25, once; release -> key_release only, no further key_long.
